// File: rtl/registro_switches.sv
// Memory-mapped switch/button input port: 2-FF synchroniser, per-bit debounce,
// sticky rising-edge pending flags with clear-on-read, and an interrupt line.
module registro_switches #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             bitAddress,
    input  logic             read,
    input  logic             regSel,
    output logic [WIDTH-1:0] dataRead,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] data_read_r;
    logic             irq_r;
    logic [CNT_W-1:0] cnt_r      [WIDTH];

    logic [CNT_W-1:0] cnt_next_s [WIDTH];
    logic [WIDTH-1:0] stable_next_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] clr_mask_s;
    logic [WIDTH-1:0] pending_next_s;
    logic             rd_acc_s;

    // Per-bit debounce: a level is accepted only after an unbroken run of differing samples
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_next_s[i] = stable_r[i];
            cnt_next_s[i]    = {CNT_W{1'b0}};
            if (sync2_r[i] == stable_r[i]) begin
                cnt_next_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_next_s[i] = sync2_r[i];
                cnt_next_s[i]    = {CNT_W{1'b0}};
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // Edge capture and clear-on-read; a rise coinciding with the clear survives
    always_comb begin
        rise_s   = stable_next_s & ~stable_r;
        rd_acc_s = bitAddress & read;
        if (rd_acc_s && regSel) begin
            clr_mask_s = pending_r;
        end else begin
            clr_mask_s = {WIDTH{1'b0}};
        end
        pending_next_s = (pending_r & ~clr_mask_s) | rise_s;
    end

    // State registers and registered bus read data / interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r     <= {WIDTH{1'b0}};
            sync2_r     <= {WIDTH{1'b0}};
            stable_r    <= {WIDTH{1'b0}};
            pending_r   <= {WIDTH{1'b0}};
            data_read_r <= {WIDTH{1'b0}};
            irq_r       <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r   <= sw_in;
            sync2_r   <= sync1_r;
            stable_r  <= stable_next_s;
            pending_r <= pending_next_s;
            irq_r     <= |pending_next_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            // Idle bus returns zero so it can be OR-combined with other peripherals
            if (rd_acc_s) begin
                data_read_r <= regSel ? pending_r : stable_r;
            end else begin
                data_read_r <= {WIDTH{1'b0}};
            end
        end
    end

    assign dataRead = data_read_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_registro_switches.sv
// Directed bench for registro_switches with a short debounce window of 4 cycles.
module tb_registro_switches;

    logic       clk;
    logic       rst;
    logic [7:0] sw_in;
    logic       bitAddress;
    logic       read;
    logic       regSel;
    logic [7:0] dataRead;
    logic       irq;
    logic [7:0] rd_val;

    int checks_cnt;
    int errors_cnt;

    registro_switches #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .bitAddress(bitAddress),
        .read(read),
        .regSel(regSel),
        .dataRead(dataRead),
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One accepted read strobe; returns the data registered on that edge
    task automatic bus_rd(input logic sel, output logic [7:0] val);
        bitAddress = 1'b1;
        read       = 1'b1;
        regSel     = sel;
        @(posedge clk);
        #1;
        read       = 1'b0;
        bitAddress = 1'b0;
        val        = dataRead;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst        = 1'b1;
        sw_in      = 8'hFF;
        bitAddress = 1'b0;
        read       = 1'b0;
        regSel     = 1'b0;

        // Reset and post-reset debounce of an input already held high
        wait_cyc(2);
        check_eq("rst_data", dataRead, 8'h00);
        check_eq("rst_irq", {7'd0, irq}, 8'h00);
        rst = 1'b0;
        wait_cyc(5);
        bus_rd(1'b0, rd_val);
        check_eq("rst_level_early", rd_val, 8'h00);
        bus_rd(1'b0, rd_val);
        check_eq("rst_level_ff", rd_val, 8'hFF);
        check_eq("rst_irq_set", {7'd0, irq}, 8'h01);
        bus_rd(1'b1, rd_val);
        check_eq("rst_pend_ff", rd_val, 8'hFF);
        check_eq("rst_irq_clr", {7'd0, irq}, 8'h00);
        sw_in = 8'h00;
        wait_cyc(8);
        bus_rd(1'b1, rd_val);
        check_eq("fall_no_pend", rd_val, 8'h00);
        bus_rd(1'b0, rd_val);
        check_eq("level_00", rd_val, 8'h00);

        // Clean step 00 -> 05
        sw_in = 8'h05;
        wait_cyc(5);
        bus_rd(1'b0, rd_val);
        check_eq("step_early", rd_val, 8'h00);
        bus_rd(1'b0, rd_val);
        check_eq("step_level", rd_val, 8'h05);
        check_eq("step_irq", {7'd0, irq}, 8'h01);
        wait_cyc(1);
        check_eq("idle_bus_zero", dataRead, 8'h00);

        // Clear-on-read
        bus_rd(1'b1, rd_val);
        check_eq("clr_pend", rd_val, 8'h05);
        check_eq("clr_irq", {7'd0, irq}, 8'h00);
        bus_rd(1'b1, rd_val);
        check_eq("clr_second", rd_val, 8'h00);

        // Bounce on bit 3, never stable long enough
        for (int k = 0; k < 5; k++) begin
            sw_in = 8'h0D;
            wait_cyc(2);
            sw_in = 8'h05;
            wait_cyc(2);
        end
        wait_cyc(8);
        bus_rd(1'b0, rd_val);
        check_eq("bounce_level", rd_val, 8'h05);
        bus_rd(1'b1, rd_val);
        check_eq("bounce_pend", rd_val, 8'h00);

        // Collision: bit 7 rises on the same edge as a pending read of 01
        sw_in = 8'h04;
        wait_cyc(8);
        bus_rd(1'b1, rd_val);
        check_eq("b0_fall_pend", rd_val, 8'h00);
        sw_in = 8'h05;
        wait_cyc(8);
        check_eq("b0_rise_irq", {7'd0, irq}, 8'h01);
        sw_in = 8'h85;
        wait_cyc(5);
        bus_rd(1'b1, rd_val);
        check_eq("coll_data", rd_val, 8'h01);
        check_eq("coll_irq", {7'd0, irq}, 8'h01);
        bus_rd(1'b1, rd_val);
        check_eq("coll_pend_after", rd_val, 8'h80);
        bus_rd(1'b0, rd_val);
        check_eq("coll_level", rd_val, 8'h85);

        // Address decode: unselected read has no effect
        sw_in = 8'h87;
        wait_cyc(8);
        bitAddress = 1'b0;
        read       = 1'b1;
        regSel     = 1'b1;
        wait_cyc(1);
        read = 1'b0;
        check_eq("dec_data", dataRead, 8'h00);
        check_eq("dec_irq", {7'd0, irq}, 8'h01);
        sw_in = 8'h85;
        wait_cyc(8);
        bus_rd(1'b1, rd_val);
        check_eq("dec_pend_kept", rd_val, 8'h02);
        check_eq("dec_irq_clr", {7'd0, irq}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
